// File: rtl/div_seq_pkg.sv
// Shared types and helpers for the iterative restoring divider.
// Operand width, state encoding and the sign fix-up used at result time.
package div_seq_pkg;

   localparam int N_DATA = 32;
   localparam int N_CNT  = $clog2(N_DATA) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DBZ  = 2'd1,
      S_ON   = 2'd2,
      S_END  = 2'd3
   } state_t;

   // Two's-complement negate when c is set; also used for operand magnitudes.
   function automatic logic [N_DATA-1:0] neg_if(input logic [N_DATA-1:0] v, input logic c);
      return c ? -v : v;
   endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the EX stage and the divider sequencer.
interface div_seq_if;
   import div_seq_pkg::*;

   logic                  i_start;
   logic                  i_signed;
   logic [N_DATA-1:0]     i_dividend;
   logic [N_DATA-1:0]     i_divisor;
   logic                  i_annul;
   logic [2*N_DATA-1:0]   o_result;
   logic                  o_ready;
   logic                  o_stall_req;

   modport master (
      output i_start, i_signed, i_dividend, i_divisor, i_annul,
      input  o_result, o_ready, o_stall_req
   );

   modport slave (
      input  i_start, i_signed, i_dividend, i_divisor, i_annul,
      output o_result, o_ready, o_stall_req
   );

endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} held in END until the request is withdrawn.
module div_seq
   import div_seq_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_rst_n,
   div_seq_if.slave  io_div
);

   state_t              r_state;
   state_t              w_state_next;
   logic [N_CNT-1:0]    r_cnt;
   logic [N_DATA-1:0]   r_dvd;      // dividend magnitude shifting out, quotient bits shifting in
   logic [N_DATA-1:0]   r_dvs;
   logic [N_DATA-1:0]   r_rem;
   logic                r_dvd_neg;
   logic                r_dvs_neg;
   logic [2*N_DATA-1:0] r_result;

   logic [N_DATA:0]     w_partial;
   logic [N_DATA:0]     w_diff;
   logic                w_qbit;
   logic [N_DATA-1:0]   w_rem_next;
   logic [N_DATA-1:0]   w_dvd_next;
   logic                w_last;
   logic                w_dvs_zero;
   logic                w_in_dvd_neg;
   logic                w_in_dvs_neg;

   // Partial remainder is N_DATA+1 bits so full-range unsigned divisors compare correctly.
   assign w_partial    = {r_rem, r_dvd[N_DATA-1]};
   assign w_diff       = w_partial - {1'b0, r_dvs};
   assign w_qbit       = ~w_diff[N_DATA];
   assign w_rem_next   = w_qbit ? w_diff[N_DATA-1:0] : w_partial[N_DATA-1:0];
   assign w_dvd_next   = {r_dvd[N_DATA-2:0], w_qbit};
   assign w_last       = (r_cnt == N_CNT'(N_DATA - 1));
   assign w_dvs_zero   = (io_div.i_divisor == '0);
   assign w_in_dvd_neg = io_div.i_signed & io_div.i_dividend[N_DATA-1];
   assign w_in_dvs_neg = io_div.i_signed & io_div.i_divisor[N_DATA-1];

   always_comb begin
      w_state_next = r_state;
      if (io_div.i_annul) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (io_div.i_start) w_state_next = w_dvs_zero ? S_DBZ : S_ON;
            S_ON:   if (w_last) w_state_next = S_END;
            S_DBZ:  w_state_next = S_END;
            S_END:  if (!io_div.i_start) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_rem     <= '0;
         r_dvd_neg <= 1'b0;
         r_dvs_neg <= 1'b0;
         r_result  <= '0;
      end else begin
         r_state <= w_state_next;
         if (io_div.i_annul) begin
            r_cnt    <= '0;
            r_result <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (io_div.i_start) begin
                     r_dvd     <= neg_if(io_div.i_dividend, w_in_dvd_neg);
                     r_dvs     <= neg_if(io_div.i_divisor, w_in_dvs_neg);
                     r_dvd_neg <= w_in_dvd_neg;
                     r_dvs_neg <= w_in_dvs_neg;
                     r_rem     <= '0;
                     r_cnt     <= '0;
                  end
               end
               S_ON: begin
                  r_dvd <= w_dvd_next;
                  r_rem <= w_rem_next;
                  r_cnt <= r_cnt + N_CNT'(1);
                  // Remainder follows the dividend sign; quotient negates on sign mismatch.
                  if (w_last) begin
                     r_result <= {neg_if(w_rem_next, r_dvd_neg),
                                  neg_if(w_dvd_next, r_dvd_neg ^ r_dvs_neg)};
                  end
               end
               S_DBZ: r_result <= '0;
               default: ;
            endcase
         end
      end
   end

   assign io_div.o_result    = r_result;
   assign io_div.o_ready     = (r_state == S_END);
   // Gated by reset so the stall request is also cleared while reset is held.
   assign io_div.o_stall_req = i_rst_n & io_div.i_start & ~io_div.o_ready & ~io_div.i_annul;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table plus annul, reset and hold sequences.
module tb_div_seq;
   import div_seq_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div_seq_if bus();

   div_seq dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_div  (bus)
   );

   typedef struct {
      logic        sgn;
      logic [31:0] dvd;
      logic [31:0] dvs;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t        vecs[14];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, expv);
      end
   endtask

   // Called at a falling edge; returns at a falling edge with the divider idle.
   task automatic run_req(input string nm, input logic sgn, input logic [31:0] dvd,
                          input logic [31:0] dvs, input logic [63:0] expv,
                          input int lat, input int hold);
      int          cyc = 0;
      int          nostall = 0;
      int          unstable = 0;
      logic [63:0] e;
      logic [63:0] got;
      bus.i_start    = 1'b1;
      bus.i_signed   = sgn;
      bus.i_dividend = dvd;
      bus.i_divisor  = dvs;
      exp_q.push_back(expv);
      #1;
      while (!bus.o_ready && cyc < 100) begin
         if (!bus.o_stall_req) nostall++;
         @(negedge clk);
         cyc++;
      end
      e = exp_q.pop_front();
      chk({nm, "_latency"}, 64'(cyc), 64'(lat));
      chk({nm, "_result"}, bus.o_result, e);
      chk({nm, "_stall_busy"}, 64'(nostall), 64'd0);
      chk({nm, "_stall_ready"}, 64'(bus.o_stall_req), 64'd0);
      got = bus.o_result;
      bus.i_dividend = ~dvd;
      bus.i_divisor  = ~dvs;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (!bus.o_ready || bus.o_result !== got) unstable++;
      end
      if (hold > 0) chk({nm, "_hold_stable"}, 64'(unstable), 64'd0);
      bus.i_start = 1'b0;
      @(negedge clk);
      chk({nm, "_ready_drop"}, 64'(bus.o_ready), 64'd0);
      $display("txn %s sgn=%0d dvd=%h dvs=%h result=%h cycles=%0d", nm, sgn, dvd, dvs, got, cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ready_seen;
      vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         33};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD},   33};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD},   33};
      vecs[3]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF,   32'd3},          33};
      vecs[4]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE,   32'hFFFFFFF2},   33};
      vecs[5]  = '{1'b0, 32'h80000000,   32'd3,          {32'd2,          32'h2AAAAAAA},   33};
      vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000,   32'd0},          33};
      vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0,          32'd1},          33};
      vecs[8]  = '{1'b0, 32'd1234,       32'd0,          {32'd0,          32'd0},          2};
      vecs[9]  = '{1'b0, 32'd5,          32'd10,         {32'd5,          32'd0},          33};
      vecs[10] = '{1'b1, 32'hFFFFFFFB,   32'd0,          {32'd0,          32'd0},          2};
      vecs[11] = '{1'b1, 32'hFFFFFFFF,   32'h80000000,   {32'hFFFFFFFF,   32'd0},          33};
      vecs[12] = '{1'b0, 32'hDEADBEEF,   32'h10,         {32'hF,          32'h0DEADBEE},   33};
      vecs[13] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000},   33};

      bus.i_start    = 1'b0;
      bus.i_signed   = 1'b0;
      bus.i_dividend = '0;
      bus.i_divisor  = '0;
      bus.i_annul    = 1'b0;

      #2;
      chk("reset_ready", 64'(bus.o_ready), 64'd0);
      chk("reset_result", bus.o_result, 64'd0);
      chk("reset_stall", 64'(bus.o_stall_req), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         run_req($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].dvd, vecs[i].dvs,
                 vecs[i].exp, vecs[i].lat, 0);
      end

      // Annul during the tenth cycle after accept, then a fresh request.
      bus.i_start    = 1'b1;
      bus.i_signed   = 1'b0;
      bus.i_dividend = 32'd999;
      bus.i_divisor  = 32'd4;
      repeat (10) @(negedge clk);
      bus.i_annul = 1'b1;
      #1;
      chk("annul_stall", 64'(bus.o_stall_req), 64'd0);
      @(negedge clk);
      bus.i_annul = 1'b0;
      bus.i_start = 1'b0;
      ready_seen = 0;
      repeat (2) begin
         #1;
         if (bus.o_ready) ready_seen++;
         @(negedge clk);
      end
      chk("annul_no_ready", 64'(ready_seen), 64'd0);
      run_req("after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 0);

      // Asynchronous reset in the middle of an operation.
      bus.i_start    = 1'b1;
      bus.i_signed   = 1'b0;
      bus.i_dividend = 32'd1000;
      bus.i_divisor  = 32'd3;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 64'(bus.o_ready), 64'd0);
      chk("midrst_result", bus.o_result, 64'd0);
      chk("midrst_stall", 64'(bus.o_stall_req), 64'd0);
      bus.i_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_req("after_rst", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33, 0);

      // Start held past ready, then an immediate back-to-back request.
      run_req("hold", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 4);
      run_req("b2b_min", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33, 0);

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
